uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_fifo.sv | 76 +++++++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Types and constants shared by the UART transmit arbiter and its FIFOs:
//   arb_state_t       launch FSM state encoding
//   WAIT_ACT_TIMEOUT  cycles the FSM waits for the UART to go busy after a
//                     launch before it treats the byte as sent
//   WAIT_CNT_W        width of the WAIT_ACT cycle counter
//   PORT_A / PORT_B   requester indices as reported on grant_src
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACT  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int   WAIT_ACT_TIMEOUT = 15;
  localparam int   WAIT_CNT_W       = 4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage : uart_tx_arbiter_pkg

// File: rtl/uart_tx_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// tx_byte_fifo
// Small synchronous byte FIFO, one per requester of the UART arbiter.
// Head-of-queue data is presented combinationally on dout.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-low reset (pointers and occupancy only)
//   push   write din this cycle (ignored when full unless pop also fires)
//   pop    remove the head entry this cycle (ignored when empty)
//   din    byte to write
//   dout   current head byte
//   full   DEPTH entries held
//   empty  no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tx_byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop in the same cycle frees the slot first, so a push into a full
  // FIFO is still accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : tx_byte_fifo

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between two byte sources (A: core,
// B: bootloader status/echo). Each source queues bytes in its own FIFO; a
// round-robin launch FSM hands one byte at a time to the UART and waits for
// the UART to report busy and then idle before launching the next.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   a_start, a_data     port A one-cycle byte request and byte
//   a_active            port A FIFO full (requester must hold off)
//   b_start, b_data     port B request and byte
//   b_active            port B FIFO full
//   uart_tx_active      UART transmitter busy
//   uart_tx_start       one-cycle launch pulse to the UART
//   uart_tx_data        byte to the UART, held until the FSM is back in IDLE
//   grant_src           source of the current/last launched byte (0=A, 1=B)
//   a_drops, b_drops    saturating counts of bytes dropped on a full FIFO
//   busy                FSM not idle or any byte still queued
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_start,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_active,
  input  logic              b_start,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_active,
  input  logic              uart_tx_active,
  output logic              uart_tx_start,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              grant_src,
  output logic [7:0]        a_drops,
  output logic [7:0]        b_drops,
  output logic              busy
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  arb_state_t            state;
  logic                  last_grant;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic [DATA_W-1:0] a_dout;
  logic [DATA_W-1:0] b_dout;
  logic              a_full;
  logic              b_full;
  logic              a_empty;
  logic              b_empty;
  logic              a_pop;
  logic              b_pop;
  logic              sel_b;
  logic              can_launch;

  tx_byte_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_start),
    .pop   (a_pop),
    .din   (a_data),
    .dout  (a_dout),
    .full  (a_full),
    .empty (a_empty)
  );

  tx_byte_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_start),
    .pop   (b_pop),
    .din   (b_data),
    .dout  (b_dout),
    .full  (b_full),
    .empty (b_empty)
  );

  assign a_active = a_full;
  assign b_active = b_full;
  assign busy     = (state != ST_IDLE) || !a_empty || !b_empty;

  // Round-robin pick: on contention the port that lost last time wins;
  // otherwise whichever port has data.
  always_comb begin
    sel_b = 1'b0;
    if (!a_empty && !b_empty) begin
      sel_b = (last_grant == PORT_A);
    end else if (a_empty && !b_empty) begin
      sel_b = 1'b1;
    end
  end

  assign can_launch = (state == ST_IDLE) && !uart_tx_active && (!a_empty || !b_empty);
  assign a_pop      = can_launch && !sel_b;
  assign b_pop      = can_launch && sel_b;

  // Launch FSM: the head byte is popped and registered on the IDLE->LAUNCH
  // edge so uart_tx_data is already valid while uart_tx_start is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
      grant_src     <= PORT_A;
      last_grant    <= PORT_B;
      wait_cnt      <= '0;
    end else begin
      uart_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (can_launch) begin
            state         <= ST_LAUNCH;
            uart_tx_start <= 1'b1;
            uart_tx_data  <= sel_b ? b_dout : a_dout;
            grant_src     <= sel_b ? PORT_B : PORT_A;
            last_grant    <= sel_b ? PORT_B : PORT_A;
          end
        end
        ST_LAUNCH: begin
          state    <= ST_WAIT_ACT;
          wait_cnt <= '0;
        end
        ST_WAIT_ACT: begin
          // A UART that never acknowledges must not stall the arbiter; after
          // the timeout the byte is considered sent.
          if (uart_tx_active) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == WAIT_CNT_W'(WAIT_ACT_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_tx_active) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A start is only lost when its FIFO is full and no pop frees a slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_drops <= 8'd0;
      b_drops <= 8'd0;
    end else begin
      if (a_start && a_full && !a_pop) begin
        a_drops <= sat_inc8(a_drops);
      end
      if (b_start && b_full && !b_pop) begin
        b_drops <= sat_inc8(b_drops);
      end
    end
  end

endmodule : uart_tx_arbiter
